// File: rtl/mmc_combo_scan.sv
// rtl/mmc_combo_scan.sv - sequential r-of-N combination scanner over a submodule availability vector
// Walks every r-of-N mask in increasing order, one per clock, and reports first hit and mask count.
module mmc_combo_scan #(
    parameter int N     = 5,
    parameter int RW    = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     nums,
    input  logic [RW-1:0]    r,
    input  logic             early_exit,
    output logic             busy,
    output logic             done,
    output logic             mask_valid,
    output logic [N-1:0]     mask,
    output logic             result,
    output logic [N-1:0]     hit_mask,
    output logic [CNT_W-1:0] combo_count
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     nums_q, nums_d;
    logic [N-1:0]     mask_q, mask_d;
    logic [N-1:0]     hit_mask_q, hit_mask_d;
    logic [RW-1:0]    r_q, r_d;
    logic             early_q, early_d;
    logic             result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N-1:0]     first_m, last_m, next_m;
    logic [N:0]       m_ext, c_ext, s_ext, ripple;
    logic [4:0]       tz;
    logic             hit;

    // first_m comes from the live r input because it is loaded on the accepting cycle
    always_comb begin
        first_m = '0;
        last_m  = '0;
        for (int i = 0; i < N; i++) begin
            first_m[i] = (i < int'(r));
            last_m[i]  = (i >= N - int'(r_q));
        end
    end

    // Gosper's step, one bit wider than the mask so the carry out of the top is not lost
    always_comb begin
        m_ext = {1'b0, mask_q};
        c_ext = m_ext & (~m_ext + {{N{1'b0}}, 1'b1});
        s_ext = m_ext + c_ext;
        tz    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_q[i]) tz = 5'(i);
        end
        ripple = ((s_ext ^ m_ext) >> 2) >> tz;
        next_m = s_ext[N-1:0] | ripple[N-1:0];
    end

    always_comb begin
        state_d    = state_q;
        nums_d     = nums_q;
        mask_d     = mask_q;
        hit_mask_d = hit_mask_q;
        r_d        = r_q;
        early_d    = early_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        hit        = ((mask_q & nums_q) == mask_q);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nums_d     = nums;
                    r_d        = r;
                    early_d    = early_exit;
                    result_d   = 1'b0;
                    hit_mask_d = '0;
                    cnt_d      = '0;
                    if (r == '0 || int'(r) > N) begin
                        state_d = S_DONE;
                    end else begin
                        mask_d  = first_m;
                        state_d = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (hit && !result_q) begin
                    result_d   = 1'b1;
                    hit_mask_d = mask_q;
                end
                if (mask_q == last_m || (hit && early_q)) begin
                    state_d = S_DONE;
                end else begin
                    mask_d = next_m;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            nums_q     <= '0;
            mask_q     <= '0;
            hit_mask_q <= '0;
            r_q        <= '0;
            early_q    <= 1'b0;
            result_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            nums_q     <= nums_d;
            mask_q     <= mask_d;
            hit_mask_q <= hit_mask_d;
            r_q        <= r_d;
            early_q    <= early_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign mask_valid  = (state_q == S_SCAN);
    assign mask        = mask_q;
    assign result      = result_q;
    assign hit_mask    = hit_mask_q;
    assign combo_count = cnt_q;

endmodule

// File: tb/tb_mmc_combo_scan.sv
// tb/tb_mmc_combo_scan.sv - self-checking bench for mmc_combo_scan (N=5)
// Expected masks come from a brute-force popcount enumeration, not from Gosper's step.
module tb_mmc_combo_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  nums;
    logic [2:0]  r;
    logic        early_exit;
    logic        busy, done, mask_valid, result;
    logic [4:0]  mask, hit_mask;
    logic [15:0] combo_count;

    mmc_combo_scan #(.N(5), .RW(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .nums(nums), .r(r),
        .early_exit(early_exit), .busy(busy), .done(done), .mask_valid(mask_valid),
        .mask(mask), .result(result), .hit_mask(hit_mask), .combo_count(combo_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [4:0]  exp_q[$];
    logic [4:0]  obs_q[$];
    int          done_cyc;
    bit          busy_ok, mv_seen, zero_ok, idle_at_start;
    logic        f_res;
    logic [4:0]  f_hit, f_mask;
    logic [15:0] f_cnt;
    logic        e_res;
    logic [4:0]  e_hit;
    int          e_k;

    // Reference: enumerate 0..31 in order, keep masks with popcount r
    task automatic model(input logic [4:0] nv, input int rv, input bit ee);
        logic [4:0] mm;
        exp_q.delete();
        e_res = 1'b0;
        e_hit = '0;
        e_k   = 0;
        if (rv == 0 || rv > 5) return;
        for (int m = 0; m < 32; m++) begin
            mm = 5'(m);
            if ($countones(mm) == rv) begin
                exp_q.push_back(mm);
                e_k++;
                if ((mm & nv) == mm && !e_res) begin
                    e_res = 1'b1;
                    e_hit = mm;
                    if (ee) break;
                end
            end
        end
    endtask

    // ev_kind: 0 none, 1 reset in cycle ev_cyc, 2 extra start pulse in cycle ev_cyc
    task automatic run_scan(input logic [4:0] nv, input logic [2:0] rv, input bit ee,
                            input int ev_kind, input int ev_cyc);
        obs_q.delete();
        done_cyc = -1;
        busy_ok  = 1;
        mv_seen  = 0;
        zero_ok  = 1;
        @(negedge clk);
        idle_at_start = (busy === 1'b0);
        nums = nv; r = rv; early_exit = ee; start = 1'b1;
        @(negedge clk);
        start = 1'b0; nums = ~nv; r = rv + 3'd1; early_exit = ~ee;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            start = (ev_kind == 2 && cyc == ev_cyc);
            if (ev_kind == 1 && cyc == ev_cyc) begin
                rst_n = 1'b0;
                #1;
                zero_ok = ({busy, done, mask_valid, result, mask, hit_mask, combo_count} === '0);
                @(negedge clk);
                if (done !== 1'b0 || busy !== 1'b0) zero_ok = 0;
                rst_n = 1'b1;
                break;
            end
            if (mask_valid === 1'b1) begin
                mv_seen = 1;
                obs_q.push_back(mask);
            end
            if (busy !== 1'b1) busy_ok = 0;
            if (done === 1'b1) begin
                done_cyc = cyc;
                f_res = result; f_hit = hit_mask; f_cnt = combo_count; f_mask = mask;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0; nums = '0; r = '0; early_exit = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; nums = '0; r = '0; early_exit = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, mask_valid, result, mask, hit_mask, combo_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b done=%b mv=%b res=%b mask=%b hit=%b cnt=%0d want all 0",
                     busy, done, mask_valid, result, mask, hit_mask, combo_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_r5;
        model(5'b11111, 5, 0);
        run_scan(5'b11111, 3'd5, 0, 0, 0);
        total++;
        if (done_cyc !== e_k + 1) begin bad++; $display("FAIL r5_done_cycle got %0d want %0d", done_cyc, e_k + 1); end
        total++;
        if ({f_res, f_hit, f_cnt} !== {e_res, e_hit, 16'(e_k)}) begin
            bad++;
            $display("FAIL r5_final got res=%b hit=%b cnt=%0d want res=%b hit=%b cnt=%0d", f_res, f_hit, f_cnt, e_res, e_hit, e_k);
        end
        total++;
        if (obs_q.size() != 1 || obs_q[0] !== 5'b11111) begin bad++; $display("FAIL r5_mask got n=%0d want one mask 11111", obs_q.size()); end
    endtask

    task automatic test_degenerate;
        logic [2:0] rs[2];
        rs[0] = 3'd0; rs[1] = 3'd7;
        for (int i = 0; i < 2; i++) begin
            model(5'b00001, int'(rs[i]), 0);
            run_scan(5'b00001, rs[i], 0, 0, 0);
            total++;
            if (done_cyc !== 1 || mv_seen || !busy_ok) begin
                bad++;
                $display("FAIL degen_r%0d_timing got done_cyc=%0d mv_seen=%0d busy_ok=%0d want 1,0,1", rs[i], done_cyc, mv_seen, busy_ok);
            end
            total++;
            if (f_res !== 1'b0 || f_cnt !== 16'd0 || f_hit !== 5'd0) begin
                bad++;
                $display("FAIL degen_r%0d_final got res=%b cnt=%0d hit=%b want 0 0 0", rs[i], f_res, f_cnt, f_hit);
            end
        end
    endtask

    task automatic test_r2(input bit ee, input int ev_kind, input int ev_cyc, input string tag);
        logic [4:0] e, o;
        model(5'b10101, 2, ee);
        run_scan(5'b10101, 3'd2, ee, ev_kind, ev_cyc);
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s_mask_count got %0d want %0d", tag, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL %s_mask got %b want %b", tag, o, e); end
        end
        total++;
        if (done_cyc !== e_k + 1 || !busy_ok) begin
            bad++;
            $display("FAIL %s_done_cycle got %0d busy_ok=%0d want %0d busy_ok=1", tag, done_cyc, busy_ok, e_k + 1);
        end
        total++;
        if ({f_res, f_hit, f_cnt} !== {e_res, e_hit, 16'(e_k)}) begin
            bad++;
            $display("FAIL %s_final got res=%b hit=%b cnt=%0d want res=%b hit=%b cnt=%0d", tag, f_res, f_hit, f_cnt, e_res, e_hit, e_k);
        end
    endtask

    task automatic test_r3;
        logic [4:0] o;
        model(5'b11011, 3, 0);
        run_scan(5'b11011, 3'd3, 0, 0, 0);
        total++;
        if ({f_res, f_hit, f_cnt} !== {e_res, e_hit, 16'(e_k)} || f_hit !== 5'b01011 || f_cnt !== 16'd10) begin
            bad++;
            $display("FAIL r3_final got res=%b hit=%b cnt=%0d want res=1 hit=01011 cnt=10", f_res, f_hit, f_cnt);
        end
        total++;
        o = (obs_q.size() > 1) ? obs_q[1] : 5'bx;
        if (o !== 5'b01011) begin bad++; $display("FAIL r3_second_mask got %b want 01011", o); end
        total++;
        if (f_mask !== 5'b11100) begin bad++; $display("FAIL r3_mask_hold got %b want 11100", f_mask); end
        model(5'b00011, 3, 0);
        run_scan(5'b00011, 3'd3, 0, 0, 0);
        total++;
        if (f_res !== 1'b0 || f_hit !== 5'd0 || f_cnt !== 16'(e_k)) begin
            bad++;
            $display("FAIL r3_nohit got res=%b hit=%b cnt=%0d want res=0 hit=0 cnt=%0d", f_res, f_hit, f_cnt, e_k);
        end
    endtask

    task automatic test_reset_mid;
        model(5'b10101, 2, 0);
        run_scan(5'b10101, 3'd2, 0, 1, 4);
        total++;
        if (!zero_ok || done_cyc != -1) begin
            bad++;
            $display("FAIL reset_mid got zero_ok=%0d done_cyc=%0d want zero_ok=1 done_cyc=-1", zero_ok, done_cyc);
        end
        total++;
        if (obs_q.size() != 3) begin bad++; $display("FAIL reset_mid_masks got %0d want 3", obs_q.size()); end
        test_r2(0, 0, 0, "restart");
    endtask

    task automatic test_back_to_back;
        model(5'b11111, 5, 0);
        run_scan(5'b11111, 3'd5, 0, 0, 0);
        model(5'b01100, 2, 1);
        run_scan(5'b01100, 3'd2, 1, 0, 0);
        total++;
        if (!idle_at_start || done_cyc !== e_k + 1 || f_hit !== e_hit || f_cnt !== 16'(e_k)) begin
            bad++;
            $display("FAIL back_to_back got idle=%0d done_cyc=%0d hit=%b cnt=%0d want idle=1 done_cyc=%0d hit=%b cnt=%0d",
                     idle_at_start, done_cyc, f_hit, f_cnt, e_k + 1, e_hit, e_k);
        end
    endtask

    initial begin
        test_reset;
        test_full_r5;
        test_degenerate;
        test_r2(0, 0, 0, "r2_full");
        test_r2(1, 0, 0, "r2_early");
        test_r3;
        test_reset_mid;
        test_r2(0, 2, 5, "ignored_start");
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
